// File: rtl/shift_unit_pkg.sv
// Shared types for the multi-step shift unit.
//   shift_mode_t  : operating mode as presented on in_mode
//   shift_state_t : control FSM states of the top-level unit
package shift_unit_pkg;

  typedef enum logic [1:0] {
    SM_ASR = 2'b00,  // arithmetic right, sign fill
    SM_LSR = 2'b01,  // logical right, zero fill
    SM_LSL = 2'b10,  // logical left, zero fill
    SM_ROR = 2'b11   // rotate right
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-step shifter: moves data by amount positions (0..STEP)
// in the selected mode.
// Ports:
//   data    in   WIDTH  value to shift
//   mode    in   2      shift_mode_t
//   amount  in   SW     positions for this step
//   result  out  WIDTH  shifted value
module shift_step_unit
  import shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SW    = 3
) (
  input  logic [WIDTH-1:0] data,
  input  shift_mode_t      mode,
  input  logic [SW-1:0]    amount,
  output logic [WIDTH-1:0] result
);

  logic [31:0] amt_ext;
  logic [31:0] back_amt;

  assign amt_ext  = 32'(amount);
  // Left shift that rebuilds the rotated-out low bits; amount 0 gives a
  // shift of WIDTH, which yields zero and leaves data unchanged.
  assign back_amt = WIDTH - amt_ext;

  always_comb begin
    result = data;
    unique case (mode)
      SM_ASR: result = WIDTH'($signed(data) >>> amt_ext);
      SM_LSR: result = data >> amt_ext;
      SM_LSL: result = data << amt_ext;
      SM_ROR: result = (data >> amt_ext) | (data << back_amt);
      default: result = data;
    endcase
  end

endmodule

// File: rtl/multi_step_shift_unit.sv
// Handshaked shifter that applies up to STEP bit positions per clock until
// the requested amount has been applied.
// Ports:
//   clk, reset           clock, async active-high reset
//   in_valid/in_ready    operand handshake (in_ready only in IDLE)
//   in_data, in_amount   operand and shift distance
//   in_mode              00 ASR, 01 LSR, 10 LSL, 11 ROR
//   clear                synchronous abort to IDLE
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   out_data             result register
//   busy                 high in SHIFT or DONE
module multi_step_shift_unit
  import shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 4,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic [1:0]       in_mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned SW = $clog2(STEP + 1);

  shift_state_t     state_q, state_d;
  shift_mode_t      mode_q, mode_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [SW-1:0]    step_amt;
  logic [AMT_W-1:0] rem_after;
  logic [WIDTH-1:0] step_data;

  // Step size is min(STEP, remaining), so remaining never underflows.
  always_comb begin
    if (32'(remaining_q) >= STEP) begin
      step_amt = SW'(STEP);
    end else begin
      step_amt = SW'(remaining_q);
    end
  end

  assign rem_after = remaining_q - AMT_W'(step_amt);

  shift_step_unit #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_step (
    .data   (data_q),
    .mode   (mode_q),
    .amount (step_amt),
    .result (step_data)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    if (clear) begin
      // Abort keeps the last out_data; a same-cycle in_valid is dropped.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_d      = in_data;
            remaining_d = in_amount;
            mode_d      = shift_mode_t'(in_mode);
            state_d     = (in_amount != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          data_d      = step_data;
          remaining_d = rem_after;
          if (rem_after == '0) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= SM_ASR;
      remaining_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_multi_step_shift_unit.sv
module tb_multi_step_shift_unit;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned STEP  = 4;
  localparam int unsigned AMT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amount;
  logic [1:0]       in_mode;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_step_shift_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_mode   (in_mode),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result: apply the mode rule one bit position at a time.
  function automatic logic [15:0] model_shift(input logic [15:0] d, input int amt,
                                              input logic [1:0] mode);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < amt; i++) begin
      case (mode)
        2'b00:   r = {r[15], r[15:1]};
        2'b01:   r = {1'b0, r[15:1]};
        2'b10:   r = {r[14:0], 1'b0};
        default: r = {r[0], r[15:1]};
      endcase
    end
    return r;
  endfunction

  // Transaction-level model: phase 0 idle, 1 working, 2 result offered.
  int          m_phase = 0;
  int          m_wait = 0;
  logic [15:0] m_result = '0;
  logic [15:0] m_out = '0;
  bit          m_known = 1'b1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_out   = '0;
      m_known = 1'b1;
    end else if (clear) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_result = model_shift(in_data, int'(in_amount), in_mode);
          m_wait   = (int'(in_amount) + STEP - 1) / STEP;
          m_out    = in_data;
          m_known  = (in_amount == 0);
          m_phase  = (m_wait == 0) ? 2 : 1;
        end
        1: begin
          m_wait--;
          if (m_wait == 0) begin
            m_phase = 2;
            m_out   = m_result;
            m_known = 1'b1;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(m_phase == 0));
    check("out_valid", 32'(out_valid), 32'(m_phase == 2));
    check("busy", 32'(busy), 32'(m_phase != 0));
    if (m_known) check("out_data", 32'(out_data), 32'(m_out));
  end

  // Called #1 after an edge with the unit idle.
  task automatic send(input string name, input logic [15:0] d, input logic [3:0] a,
                      input logic [1:0] m, input logic [15:0] exp, input int exp_lat,
                      input bit scramble, input int hold);
    int lat;
    lat       = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = a;
    in_mode   = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (scramble) begin
      in_data   = ~d;
      in_mode   = ~m;
      in_amount = ~a;
    end
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " data"}, 32'(out_data), 32'(exp));
    if (hold > 0) in_valid = 1'b1;  // must be ignored while the result waits
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, " hold valid"}, 32'(out_valid), 32'd1);
      check({name, " hold ready"}, 32'(in_ready), 32'd0);
      check({name, " hold data"}, 32'(out_data), 32'(exp));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({name, " back idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amount = '0;
    in_mode   = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    #3;
    check("reset out_data", 32'(out_data), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    send("asr5", 16'h8000, 4'd5, 2'b00, 16'hFC00, 2, 1'b0, 0);
    send("lsr15", 16'h8000, 4'd15, 2'b01, 16'h0001, 4, 1'b0, 0);
    send("lsl4", 16'h0003, 4'd4, 2'b10, 16'h0030, 1, 1'b0, 0);
    send("ror1", 16'h0001, 4'd1, 2'b11, 16'h8000, 1, 1'b0, 0);
    send("asr0", 16'h1234, 4'd0, 2'b00, 16'h1234, 0, 1'b0, 0);
    send("ror0", 16'hA5A5, 4'd0, 2'b11, 16'hA5A5, 0, 1'b0, 0);
    send("ror8", 16'h1234, 4'd8, 2'b11, 16'h3412, 2, 1'b0, 0);
    send("ror6", 16'h000F, 4'd6, 2'b11, 16'h3C00, 2, 1'b0, 0);
    send("asr7pos", 16'h7FF0, 4'd7, 2'b00, 16'h00FF, 2, 1'b0, 0);
    send("asr15", 16'h8001, 4'd15, 2'b00, 16'hFFFF, 4, 1'b0, 0);
    send("lsl12", 16'h8001, 4'd12, 2'b10, 16'h1000, 3, 1'b0, 0);
    send("bp", 16'h00F0, 4'd3, 2'b01, 16'h001E, 1, 1'b0, 3);
    send("b2b", 16'h0F00, 4'd8, 2'b10, 16'h0000, 2, 1'b0, 0);
    send("latched", 16'h8000, 4'd15, 2'b01, 16'h0001, 4, 1'b1, 0);

    // Abort mid-shift: one 4-bit step applied, then clear.
    in_valid  = 1'b1;
    in_data   = 16'h8000;
    in_amount = 4'd15;
    in_mode   = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear in_ready", 32'(in_ready), 32'd1);
    check("clear busy", 32'(busy), 32'd0);
    check("clear out_valid", 32'(out_valid), 32'd0);
    check("clear data held", 32'(out_data), 32'h0800);

    // clear beats a same-cycle accept.
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hBEEF;
    in_amount = 4'd0;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear+valid in_ready", 32'(in_ready), 32'd1);
    check("clear+valid data", 32'(out_data), 32'h0800);

    // Async reset mid-shift, observed before any further clock edge.
    in_valid  = 1'b1;
    in_data   = 16'h8000;
    in_amount = 4'd15;
    in_mode   = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("async rst data", 32'(out_data), 32'h0);
    check("async rst valid", 32'(out_valid), 32'd0);
    check("async rst ready", 32'(in_ready), 32'd1);
    check("async rst busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    send("post rst", 16'h4000, 4'd2, 2'b00, 16'h1000, 1, 1'b0, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
